id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that feeds the ALU's in1, in2 and operation inputs.
- Captures decoded operands and control each cycle.
- Resolves data hazards with EX/MEM and MEM/WB forwarding.
- Detects load-use hazards and inserts bubbles. Handles downstream stall and branch flush.

Parameters:
- n, 64, datapath width (matches ALU n)
- RW, 5, register-number width; register 31 is XZR

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- id_valid  input  1  decode slot holds a real instruction
- id_rd1  input  n  register-file read data for Rn
- id_rd2  input  n  register-file read data for Rm/Rt
- id_imm  input  n  sign-extended immediate
- id_rn, id_rm, id_rd  input  RW each  source and destination register numbers
- id_alu_src  input  1  1 selects immediate for in2
- id_alu_op  input  4  ALU operation code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 pass-in2, 1100 XOR)
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  input  1 each  control bits
- stall  input  1  downstream freeze
- flush  input  1  branch-redirect kill
- exmem_reg_write  input  1  EX/MEM stage writes a register
- exmem_rd  input  RW  EX/MEM destination register
- exmem_result  input  n  EX/MEM ALU result
- memwb_reg_write  input  1  MEM/WB stage writes a register
- memwb_rd  input  RW  MEM/WB destination register
- memwb_result  input  n  MEM/WB writeback value
- ex_valid  output  1  EX slot holds a real instruction
- ex_in1  output  n  ALU in1
- ex_in2  output  n  ALU in2
- ex_operation  output  4  ALU operation
- ex_store_data  output  n  forwarded Rm/Rt value for stores
- ex_rd  output  RW  destination register
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  output  1 each  control, forced 0 when ex_valid=0
- load_use_stall  output  1  combinational request to freeze PC and IF/ID

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Registered state: valid, rd1, rd2, imm, rn, rm, rd, alu_src, alu_op, and the 5 control bits. All reset to 0.
- Reset outputs: ex_valid=0, ex_operation=0000, all data and control outputs 0.
- Per-edge update priority:
  - reset: clear all state.
  - flush: valid←0, other fields don't-care (zeroed).
  - stall: hold all state.
  - load_use_stall: insert bubble, valid←0.
  - otherwise: load all id_* fields, valid←id_valid.
- Latency: one cycle from id_* to ex_*.
- load_use_stall is asserted when all of the following hold:
  - valid=1 and ex_mem_read=1;
  - rd≠31;
  - id_valid=1;
  - id_rn==rd, or (id_rm==rd and id_alu_src=0), or (id_rm==rd and id_mem_write=1).
  - It is combinational and does not depend on stall or flush.
- Forwarding (combinational, applied to the registered rn/rm):
  - Source A: exmem_reg_write=1, exmem_rd≠31, exmem_rd==reg → exmem_result.
  - Else source B: memwb_reg_write=1, memwb_rd≠31, memwb_rd==reg → memwb_result.
  - Else the registered rd1/rd2.
  - EX/MEM has priority over MEM/WB. Register 31 is never forwarded.
- Operand outputs:
  - fwdA = forwarded Rn; fwdB = forwarded Rm.
  - ex_in1 = fwdA.
  - ex_in2 = imm when alu_src=1, else fwdB.
  - ex_store_data = fwdB.
  - ex_operation = alu_op.
- When valid=0: ex_in1, ex_in2 and ex_store_data are 0; ex_operation=0000; all control outputs are 0.
- Simultaneous events:
  - flush+stall → flush wins.
  - stall+load_use_stall → hold; the bubble is inserted on the first non-stalled edge if the hazard persists.
- Reset asserted mid-stall or mid-hazard clears everything on that edge. The first edge after reset deasserts loads normally.

Test Plan:
- Reset then ADD: reset 1 cycle, then id_valid=1, id_rd1=5, id_rd2=7, alu_src=0, op=0010, rd=3 → next cycle ex_valid=1, ex_in1=5, ex_in2=7, ex_operation=0010, ex_rd=3; before that edge all outputs 0.
- Forward priority: EX holds rn=2, rm=4; exmem_rd=2, exmem_result=0x11; memwb_rd=2, memwb_result=0x22; memwb_rd also drives rm match with value 0x33 via a second cycle → ex_in1=0x11 (EX/MEM wins); with exmem_reg_write=0, ex_in1=0x22.
- XZR: rn=31, exmem_rd=31, exmem_reg_write=1, exmem_result=0xFF, rd1=0 → ex_in1=0, no forward.
- Load-use: EX holds LDUR rd=9 (mem_read=1); ID has rn=9 → load_use_stall=1; next edge ex_valid=0 with controls 0; the following edge loads the dependent instruction, and memwb forwarding supplies its operand.
- Stall/flush: load op=0110, then stall=1 for 3 cycles → outputs unchanged; assert flush with stall=1 → ex_valid=0 next edge.
- Immediate path: alu_src=1, imm=0x40, rm matches exmem_rd → ex_in2=0x40, ex_store_data=exmem_result.

Source files
------------

// File: rtl/id_ex_if.sv
// id_ex_if: bundles the decode-slot inputs, the hazard control, the forwarding
// sources and the EX-slot outputs of the ID/EX pipeline register.
//   master : decode / hazard / later-stage side (drives id_*, stall, flush,
//            exmem_*, memwb_*; observes ex_* and load_use_stall)
//   slave  : the id_ex_stage itself
// Handshake: there is no valid/ready pair. id_valid qualifies the decode slot
// and is loaded whenever the stage is not stalled, flushed or bubbling.
// load_use_stall asks upstream to freeze PC and IF/ID. stall freezes this stage.
interface id_ex_if #(
  parameter int n  = 64,
  parameter int RW = 5
);
  logic          id_valid;
  logic [n-1:0]  id_rd1;
  logic [n-1:0]  id_rd2;
  logic [n-1:0]  id_imm;
  logic [RW-1:0] id_rn;
  logic [RW-1:0] id_rm;
  logic [RW-1:0] id_rd;
  logic          id_alu_src;
  logic [3:0]    id_alu_op;
  logic          id_reg_write;
  logic          id_mem_read;
  logic          id_mem_write;
  logic          id_mem_to_reg;
  logic          id_branch;
  logic          stall;
  logic          flush;
  logic          exmem_reg_write;
  logic [RW-1:0] exmem_rd;
  logic [n-1:0]  exmem_result;
  logic          memwb_reg_write;
  logic [RW-1:0] memwb_rd;
  logic [n-1:0]  memwb_result;
  logic          ex_valid;
  logic [n-1:0]  ex_in1;
  logic [n-1:0]  ex_in2;
  logic [3:0]    ex_operation;
  logic [n-1:0]  ex_store_data;
  logic [RW-1:0] ex_rd;
  logic          ex_reg_write;
  logic          ex_mem_read;
  logic          ex_mem_write;
  logic          ex_mem_to_reg;
  logic          ex_branch;
  logic          load_use_stall;

  modport master (
    output id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_alu_src,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    input  ex_valid, ex_in1, ex_in2, ex_operation, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
           load_use_stall
  );

  modport slave (
    input  id_valid, id_rd1, id_rd2, id_imm, id_rn, id_rm, id_rd, id_alu_src,
           id_alu_op, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
           id_branch, stall, flush, exmem_reg_write, exmem_rd, exmem_result,
           memwb_reg_write, memwb_rd, memwb_result,
    output ex_valid, ex_in1, ex_in2, ex_operation, ex_store_data, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch,
           load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : id_ex_if.slave (decode slot in, hazard control, forwarding
//                sources, ALU operands/control out, load_use_stall out)
// Edge priority: reset > flush > stall (hold) > load-use bubble > load.
// Operands are forwarded from EX/MEM (first) or MEM/WB onto the registered
// rn/rm; register 31 (XZR) is never forwarded. Outputs read 0 when the slot
// is empty.
module id_ex_stage #(
  parameter int n  = 64,
  parameter int RW = 5
) (
  input  logic      clk,
  input  logic      reset,
  id_ex_if.slave    bus
);
  localparam logic [RW-1:0] XZR = {RW{1'b1}};

  typedef struct packed {
    logic          valid;
    logic [n-1:0]  rd1;
    logic [n-1:0]  rd2;
    logic [n-1:0]  imm;
    logic [RW-1:0] rn;
    logic [RW-1:0] rm;
    logic [RW-1:0] rd;
    logic          alu_src;
    logic [3:0]    alu_op;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic          branch;
  } slot_t;

  slot_t         slot_q, slot_d;
  logic          load_use;
  logic [n-1:0]  fwd_a, fwd_b;

  // The dependent instruction in ID reads the loaded register as Rn, or as Rm
  // when Rm is an ALU operand (alu_src=0) or store data (mem_write=1).
  always_comb begin
    load_use = slot_q.valid && slot_q.mem_read && (slot_q.rd != XZR) &&
               bus.id_valid &&
               ((bus.id_rn == slot_q.rd) ||
                ((bus.id_rm == slot_q.rd) && (!bus.id_alu_src || bus.id_mem_write)));
  end

  always_comb begin
    slot_d = slot_q;
    if (bus.flush) begin
      slot_d = '0;
    end else if (bus.stall) begin
      slot_d = slot_q;
    end else if (load_use) begin
      slot_d = '0;
    end else begin
      slot_d.valid      = bus.id_valid;
      slot_d.rd1        = bus.id_rd1;
      slot_d.rd2        = bus.id_rd2;
      slot_d.imm        = bus.id_imm;
      slot_d.rn         = bus.id_rn;
      slot_d.rm         = bus.id_rm;
      slot_d.rd         = bus.id_rd;
      slot_d.alu_src    = bus.id_alu_src;
      slot_d.alu_op     = bus.id_alu_op;
      slot_d.reg_write  = bus.id_reg_write;
      slot_d.mem_read   = bus.id_mem_read;
      slot_d.mem_write  = bus.id_mem_write;
      slot_d.mem_to_reg = bus.id_mem_to_reg;
      slot_d.branch     = bus.id_branch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) slot_q <= '0;
    else       slot_q <= slot_d;
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB.
  always_comb begin
    fwd_a = slot_q.rd1;
    if (bus.exmem_reg_write && (bus.exmem_rd != XZR) && (bus.exmem_rd == slot_q.rn))
      fwd_a = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != XZR) && (bus.memwb_rd == slot_q.rn))
      fwd_a = bus.memwb_result;
  end

  always_comb begin
    fwd_b = slot_q.rd2;
    if (bus.exmem_reg_write && (bus.exmem_rd != XZR) && (bus.exmem_rd == slot_q.rm))
      fwd_b = bus.exmem_result;
    else if (bus.memwb_reg_write && (bus.memwb_rd != XZR) && (bus.memwb_rd == slot_q.rm))
      fwd_b = bus.memwb_result;
  end

  always_comb begin
    bus.ex_valid       = slot_q.valid;
    bus.ex_in1         = '0;
    bus.ex_in2         = '0;
    bus.ex_store_data  = '0;
    bus.ex_operation   = 4'b0000;
    bus.ex_rd          = '0;
    bus.ex_reg_write   = 1'b0;
    bus.ex_mem_read    = 1'b0;
    bus.ex_mem_write   = 1'b0;
    bus.ex_mem_to_reg  = 1'b0;
    bus.ex_branch      = 1'b0;
    if (slot_q.valid) begin
      bus.ex_in1        = fwd_a;
      bus.ex_in2        = slot_q.alu_src ? slot_q.imm : fwd_b;
      bus.ex_store_data = fwd_b;
      bus.ex_operation  = slot_q.alu_op;
      bus.ex_rd         = slot_q.rd;
      bus.ex_reg_write  = slot_q.reg_write;
      bus.ex_mem_read   = slot_q.mem_read;
      bus.ex_mem_write  = slot_q.mem_write;
      bus.ex_mem_to_reg = slot_q.mem_to_reg;
      bus.ex_branch     = slot_q.branch;
    end
    bus.load_use_stall = load_use;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;
  localparam int N  = 64;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_ex_if #(.n(N), .RW(RW)) bus ();
  id_ex_stage #(.n(N), .RW(RW)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Reference: the contents of the EX slot as an instruction record.
  typedef struct {
    bit          valid;
    bit [N-1:0]  rd1, rd2, imm;
    int          rn, rm, rd;
    bit          alu_src;
    bit [3:0]    op;
    bit          rw, mr, mw, m2r, br;
  } instr_t;

  instr_t mdl;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit [N-1:0] forward(input int r, input bit [N-1:0] file_val);
    if (bus.exmem_reg_write && bus.exmem_rd != 31 && int'(bus.exmem_rd) == r) return bus.exmem_result;
    if (bus.memwb_reg_write && bus.memwb_rd != 31 && int'(bus.memwb_rd) == r) return bus.memwb_result;
    return file_val;
  endfunction

  function automatic bit model_hazard();
    int rn, rm;
    rn = int'(bus.id_rn);
    rm = int'(bus.id_rm);
    return mdl.valid && mdl.mr && mdl.rd != 31 && bus.id_valid &&
           (rn == mdl.rd || (rm == mdl.rd && (!bus.id_alu_src || bus.id_mem_write)));
  endfunction

  task automatic check_model();
    bit [N-1:0] a, b;
    a = forward(mdl.rn, mdl.rd1);
    b = forward(mdl.rm, mdl.rd2);
    chk("load_use_stall", N'(bus.load_use_stall), N'(model_hazard()));
    chk("ex_valid", N'(bus.ex_valid), N'(mdl.valid));
    chk("ex_in1", bus.ex_in1, mdl.valid ? a : '0);
    chk("ex_in2", bus.ex_in2, mdl.valid ? (mdl.alu_src ? mdl.imm : b) : '0);
    chk("ex_store_data", bus.ex_store_data, mdl.valid ? b : '0);
    chk("ex_operation", N'(bus.ex_operation), mdl.valid ? N'(mdl.op) : '0);
    chk("ex_ctrl", N'({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write, bus.ex_mem_to_reg, bus.ex_branch}),
        mdl.valid ? N'({mdl.rw, mdl.mr, mdl.mw, mdl.m2r, mdl.br}) : '0);
    if (mdl.valid) chk("ex_rd", N'(bus.ex_rd), N'(mdl.rd));
  endtask

  // Check the settled outputs, work out the slot after the edge, take the edge.
  task automatic tick(input bit do_check = 1'b1);
    instr_t nxt;
    #2;
    if (do_check) check_model();
    nxt = mdl;
    if (reset || bus.flush) nxt = '{default: 0};
    else if (bus.stall) nxt = mdl;
    else if (model_hazard()) nxt = '{default: 0};
    else begin
      nxt.valid = bus.id_valid;   nxt.rd1 = bus.id_rd1;  nxt.rd2 = bus.id_rd2;
      nxt.imm = bus.id_imm;       nxt.rn = int'(bus.id_rn); nxt.rm = int'(bus.id_rm);
      nxt.rd = int'(bus.id_rd);   nxt.alu_src = bus.id_alu_src; nxt.op = bus.id_alu_op;
      nxt.rw = bus.id_reg_write;  nxt.mr = bus.id_mem_read; nxt.mw = bus.id_mem_write;
      nxt.m2r = bus.id_mem_to_reg; nxt.br = bus.id_branch;
    end
    @(posedge clk);
    #1;
    mdl = nxt;
  endtask

  task automatic set_id(input bit v, input bit [N-1:0] r1, input bit [N-1:0] r2, input bit [N-1:0] im,
                        input int rn, input int rm, input int rd, input bit src, input bit [3:0] op,
                        input bit rw, input bit mr, input bit mw);
    bus.id_valid = v;  bus.id_rd1 = r1;  bus.id_rd2 = r2;  bus.id_imm = im;
    bus.id_rn = RW'(rn); bus.id_rm = RW'(rm); bus.id_rd = RW'(rd);
    bus.id_alu_src = src; bus.id_alu_op = op;
    bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
    bus.id_mem_to_reg = mr; bus.id_branch = 1'b0;
  endtask

  task automatic idle_inputs();
    set_id(0, '0, '0, '0, 0, 0, 0, 0, 4'b0000, 0, 0, 0);
    bus.stall = 0; bus.flush = 0;
    bus.exmem_reg_write = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_reg_write = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  function automatic int rand_reg();
    return ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 3));
  endfunction

  function automatic bit [N-1:0] rand_word();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    mdl = '{default: 0};
    idle_inputs();
    reset = 1;
    tick(0);
    reset = 0;

    // Reset then ADD
    set_id(1, 5, 7, 0, 1, 2, 3, 0, 4'b0010, 1, 0, 0);
    #2; chk("reset_ex_valid", N'(bus.ex_valid), '0);
    chk("reset_in1", bus.ex_in1, '0);
    tick();
    idle_inputs();
    #2; chk("add_in1", bus.ex_in1, 5); chk("add_in2", bus.ex_in2, 7);
    chk("add_op", N'(bus.ex_operation), N'(4'b0010)); chk("add_rd", N'(bus.ex_rd), 3);

    // Forward priority on a held instruction
    set_id(1, 1, 2, 0, 2, 4, 6, 0, 4'b0010, 1, 0, 0);
    tick();
    idle_inputs();
    bus.stall = 1;
    bus.exmem_reg_write = 1; bus.exmem_rd = 2; bus.exmem_result = 'h11;
    bus.memwb_reg_write = 1; bus.memwb_rd = 2; bus.memwb_result = 'h22;
    #2; chk("fwd_exmem_wins", bus.ex_in1, 'h11);
    tick();
    bus.exmem_reg_write = 0;
    #2; chk("fwd_memwb", bus.ex_in1, 'h22);
    tick();
    bus.memwb_rd = 4; bus.memwb_result = 'h33;
    #2; chk("fwd_rm_memwb", bus.ex_in2, 'h33); chk("fwd_rn_file", bus.ex_in1, 1);
    tick();

    // XZR is never forwarded
    idle_inputs();
    set_id(1, 0, 0, 0, 31, 0, 1, 0, 4'b0010, 1, 0, 0);
    tick();
    idle_inputs();
    bus.stall = 1;
    bus.exmem_reg_write = 1; bus.exmem_rd = 31; bus.exmem_result = 'hFF;
    #2; chk("xzr_in1", bus.ex_in1, 0);
    tick();

    // Load-use bubble then memwb forwarding
    idle_inputs();
    set_id(1, 8, 0, 16, 1, 0, 9, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 0, 4, 0, 9, 2, 10, 0, 4'b0010, 1, 0, 0);
    #2; chk("lu_asserted", N'(bus.load_use_stall), 1);
    tick();
    #2; chk("bubble_valid", N'(bus.ex_valid), 0); chk("bubble_mem_read", N'(bus.ex_mem_read), 0);
    chk("bubble_lu_clear", N'(bus.load_use_stall), 0);
    tick();
    bus.memwb_reg_write = 1; bus.memwb_rd = 9; bus.memwb_result = 'hABC;
    #2; chk("lu_fwd_in1", bus.ex_in1, 'hABC); chk("lu_dep_valid", N'(bus.ex_valid), 1);
    tick();

    // Stall then flush
    idle_inputs();
    set_id(1, 10, 3, 0, 0, 1, 5, 0, 4'b0110, 1, 0, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_id(1, rand_word(), rand_word(), rand_word(), 2, 3, 4, 0, 4'b0000, 1, 0, 0);
      bus.stall = 1;
      #2; chk("stall_op", N'(bus.ex_operation), N'(4'b0110)); chk("stall_in1", bus.ex_in1, 10);
      tick();
    end
    bus.flush = 1;
    tick();
    #2; chk("flush_valid", N'(bus.ex_valid), 0);

    // Immediate path with forwarded store data
    idle_inputs();
    set_id(1, 2, 1, 'h40, 0, 5, 6, 1, 4'b0010, 0, 0, 1);
    tick();
    idle_inputs();
    bus.stall = 1;
    bus.exmem_reg_write = 1; bus.exmem_rd = 5; bus.exmem_result = 'h77;
    #2; chk("imm_in2", bus.ex_in2, 'h40); chk("imm_store", bus.ex_store_data, 'h77);
    tick();

    // Reset in the middle of a load-use hazard
    idle_inputs();
    set_id(1, 0, 0, 0, 1, 0, 12, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 12, 0, 13, 0, 4'b0010, 1, 0, 0);
    bus.stall = 1;
    reset = 1;
    tick();
    reset = 0;
    #2; chk("mid_reset_valid", N'(bus.ex_valid), 0);
    bus.stall = 0;
    tick();
    #2; chk("post_reset_load", N'(bus.ex_rd), 13);

    // Random traffic against the reference
    for (int i = 0; i < 400; i++) begin
      set_id($urandom_range(0, 3) != 0, rand_word(), rand_word(), rand_word(),
             rand_reg(), rand_reg(), rand_reg(), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      bus.id_branch = 1'($urandom_range(0, 1));
      bus.stall = ($urandom_range(0, 5) == 0);
      bus.flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 49) == 0);
      bus.exmem_reg_write = 1'($urandom_range(0, 1));
      bus.exmem_rd = RW'(rand_reg()); bus.exmem_result = rand_word();
      bus.memwb_reg_write = 1'($urandom_range(0, 1));
      bus.memwb_rd = RW'(rand_reg()); bus.memwb_result = rand_word();
      tick();
    end
    reset = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
